dll_tap_ctrl: RTL

Closed-loop tap-select controller for the 256-tap DLL delay line.
- Consumes a sampled phase-detector decision, which compares the delayed clock against the reference.
- Steps the 8-bit tap index one position at a time until the loop locks, then keeps tracking drift with hysteresis.
- Sits directly upstream of the delay line and drives its sel_index input.
- Software can bypass calibration with a fixed tap.

---
 rtl/dll_tap_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dll_tap_ctrl.sv
// Closed-loop tap-select controller for the 256-tap DLL delay line.
// Steps the tap by majority vote of the phase detector until lock, then tracks with hysteresis.
module dll_tap_ctrl #(
    parameter int INIT_TAP   = 128,
    parameter int SETTLE_CYC = 8,
    parameter int VOTE_N     = 16,
    parameter int LOCK_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cal_start,
    input  logic       i_cal_abort,
    input  logic       i_pd_valid,
    input  logic       i_pd_late,
    input  logic       i_ovr_en,
    input  logic [7:0] i_ovr_tap,
    output logic [7:0] o_sel_index,
    output logic       o_tap_upd,
    output logic       o_busy,
    output logic       o_locked,
    output logic       o_sat_err
);

    localparam int VW = $clog2(VOTE_N) + 2;
    localparam int SW = $clog2(VOTE_N) + 1;
    localparam int CW = $clog2(SETTLE_CYC + 1) + 1;
    localparam int RW = $clog2(LOCK_CNT + 1) + 1;

    localparam logic signed [VW-1:0] VOTE_ONE  = 1;
    localparam logic        [VW-1:0] VOTE_HALF = VW'(VOTE_N / 2);
    localparam logic        [SW-1:0] SAMP_LAST = SW'(VOTE_N - 1);
    localparam logic        [CW-1:0] SETL_LAST = CW'(SETTLE_CYC);
    localparam logic        [RW-1:0] LOCK_C    = RW'(LOCK_CNT);
    localparam logic        [7:0]    INIT      = 8'(INIT_TAP);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADJUST} state_t;

    state_t                 state;
    logic signed [VW-1:0]   vote;
    logic        [SW-1:0]   samp_cnt;
    logic        [CW-1:0]   settle_cnt;
    logic        [RW-1:0]   rev_cnt;
    logic                   last_vld;
    logic                   last_up;

    logic          vote_neg, vote_pos, vote_zero, sat_hit, is_rev;
    logic [VW-1:0] vote_mag;
    logic [RW-1:0] rev_nxt;
    logic [7:0]    tap_step;

    assign vote_neg  = vote[VW-1];
    assign vote_zero = (vote == '0);
    assign vote_pos  = !vote_neg && !vote_zero;
    assign vote_mag  = vote_neg ? -vote : vote;
    assign sat_hit   = (vote_pos && o_sel_index == 8'hFF) || (vote_neg && o_sel_index == 8'h00);
    assign is_rev    = vote_zero || (last_vld && (last_up != vote_pos));
    assign rev_nxt   = is_rev ? rev_cnt + RW'(1) : '0;
    assign tap_step  = vote_pos ? o_sel_index + 8'd1 : o_sel_index - 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            o_sel_index <= INIT;
            o_tap_upd   <= 1'b0;
            o_busy      <= 1'b0;
            o_locked    <= 1'b0;
            o_sat_err   <= 1'b0;
            vote        <= '0;
            samp_cnt    <= '0;
            settle_cnt  <= '0;
            rev_cnt     <= '0;
            last_vld    <= 1'b0;
            last_up     <= 1'b0;
        end else if (i_ovr_en) begin
            o_sel_index <= i_ovr_tap;
            o_tap_upd   <= (i_ovr_tap != o_sel_index);
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_locked    <= 1'b0;
            vote        <= '0;
            samp_cnt    <= '0;
            settle_cnt  <= '0;
            rev_cnt     <= '0;
        end else if (i_cal_abort) begin
            state      <= IDLE;
            o_tap_upd  <= 1'b0;
            o_busy     <= 1'b0;
            o_locked   <= 1'b0;
            vote       <= '0;
            samp_cnt   <= '0;
            settle_cnt <= '0;
            rev_cnt    <= '0;
        end else begin
            o_tap_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cal_start) begin
                        // Starting from 0 gives the first settle one extra cycle
                        // versus the in-loop settle that starts at 1.
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        o_sat_err  <= 1'b0;
                        o_locked   <= 1'b0;
                        rev_cnt    <= '0;
                        o_busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETL_LAST) state <= SAMPLE;
                    else settle_cnt <= settle_cnt + CW'(1);
                end
                SAMPLE: begin
                    if (i_pd_valid) begin
                        vote     <= i_pd_late ? vote - VOTE_ONE : vote + VOTE_ONE;
                        samp_cnt <= samp_cnt + SW'(1);
                        if (samp_cnt == SAMP_LAST) state <= ADJUST;
                    end
                end
                ADJUST: begin
                    vote       <= '0;
                    samp_cnt   <= '0;
                    settle_cnt <= CW'(1);
                    state      <= SETTLE;
                    if (o_locked) begin
                        // Tracking: only a clear majority moves the tap.
                        if (vote_mag >= VOTE_HALF) begin
                            if (sat_hit) o_sat_err <= 1'b1;
                            else begin
                                o_sel_index <= tap_step;
                                o_tap_upd   <= 1'b1;
                            end
                        end
                    end else if (sat_hit) begin
                        o_sat_err <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        if (!vote_zero) begin
                            o_sel_index <= tap_step;
                            o_tap_upd   <= 1'b1;
                            last_vld    <= 1'b1;
                            last_up     <= vote_pos;
                        end
                        rev_cnt <= rev_nxt;
                        if (rev_nxt >= LOCK_C) begin
                            o_locked <= 1'b1;
                            o_busy   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
